// File: rtl/flow_read_scheduler.sv
// flow_read_scheduler: source side of the flowControl pause protocol.
// Drains N = FIFO_COUNT-1 source FIFOs round-robin. A channel is popped only
// while flowControl grants cf[i]. Each popped word is forwarded downstream one
// cycle later with a valid strobe and its channel index. A small FSM tracks
// idle/active/paused operation and counts the cycles spent paused.
module flow_read_scheduler #(
  parameter  int FIFO_COUNT = 5,
  parameter  int DATA_WIDTH = 6,
  localparam int N          = FIFO_COUNT - 1,
  localparam int CW         = (N > 1) ? $clog2(N) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic [N-1:0]          cf,
  input  logic [N-1:0]          empty_in,
  input  logic [N-1:0]          almost_empty_in,
  input  logic [N*DATA_WIDTH-1:0] data_in,
  output logic [N-1:0]          pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [CW-1:0]         chan_out,
  output logic                  paused,
  output logic [7:0]            pause_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         rr_ptr;
  logic [N-1:0]          pop_q;
  logic [CW-1:0]         pop_chan_q;

  logic [N-1:0]          elig;
  logic                  any_elig;
  logic                  any_nonempty;
  logic                  cf_blocked;
  logic                  pick_valid;
  logic [CW-1:0]         pick_idx;
  logic [N-1:0]          pop_d;
  logic [CW-1:0]         rr_next;
  logic [DATA_WIDTH-1:0] sel_word;
  int                    cand;

  // A channel may be popped when granted, non-empty, and not about to underflow:
  // the empty flag lags a pop by one cycle, so a channel popped this cycle with
  // almost_empty set must sit out one pick.
  always_comb begin
    elig         = enb ? (cf & ~empty_in & ~(pop_q & almost_empty_in)) : '0;
    any_elig     = |elig;
    any_nonempty = |(~empty_in);
    cf_blocked   = any_nonempty & ~(|(cf & ~empty_in));
  end

  // Round-robin pick: first eligible channel at or after rr_ptr, wrapping N-1 -> 0.
  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < N; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!pick_valid && elig[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = CW'(cand);
      end
    end
    pop_d   = pick_valid ? (N'(1) << pick_idx) : '0;
    rr_next = (pick_idx == CW'(N - 1)) ? '0 : pick_idx + CW'(1);
  end

  // Pop strobe and pointer registers; pop is the registered one-hot of the pick.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_q      <= '0;
      pop_chan_q <= '0;
      rr_ptr     <= '0;
    end else begin
      pop_q <= pop_d;
      if (pick_valid) begin
        pop_chan_q <= pick_idx;
        rr_ptr     <= rr_next;
      end
    end
  end

  // Select the read data of the channel currently being popped.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (pop_q[i]) sel_word = data_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Capture the popped word one cycle after its pop; this happens even with
  // enb low because the source FIFO has already advanced.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out  <= '0;
      chan_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |pop_q;
      if (|pop_q) begin
        data_out <= sel_word;
        chan_out <= pop_chan_q;
      end
    end
  end

  // FSM state register; state freezes while enb is low.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic and paused decode.
  always_comb begin
    state_d = state_q;
    paused  = (state_q == S_PAUSED);
    if (enb) begin
      unique case (state_q)
        S_IDLE: begin
          if (any_elig)        state_d = S_ACTIVE;
          else if (cf_blocked) state_d = S_PAUSED;
        end
        S_ACTIVE: begin
          if (!any_nonempty)   state_d = S_IDLE;
          else if (cf_blocked) state_d = S_PAUSED;
        end
        S_PAUSED: begin
          if (any_elig)           state_d = S_ACTIVE;
          else if (!any_nonempty) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Saturating count of paused cycles, stepped for each cycle that is spent
  // in PAUSED; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pause_count <= '0;
    end else if (enb && state_d == S_PAUSED && pause_count != 8'hFF) begin
      pause_count <= pause_count + 8'd1;
    end
  end

  assign pop = pop_q;

endmodule

// File: tb/tb_flow_read_scheduler.sv
// Self-checking bench for flow_read_scheduler: a negedge monitor scoreboards
// every popped word against the delivered data, and per-feature tasks check
// pop sequencing, pausing, underflow guard, enable gating and saturation.
module tb_flow_read_scheduler;
  localparam int FIFO_COUNT = 5;
  localparam int DW         = 6;
  localparam int N          = FIFO_COUNT - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            enb;
  logic [N-1:0]    cf;
  logic [N-1:0]    empty_in;
  logic [N-1:0]    almost_empty_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    pop;
  logic [DW-1:0]   data_out;
  logic            valid_out;
  logic [1:0]      chan_out;
  logic            paused;
  logic [7:0]      pause_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    chan;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic mon_en    = 1'b0;
  logic exp_valid = 1'b0;

  flow_read_scheduler #(.FIFO_COUNT(FIFO_COUNT), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .enb             (enb),
    .cf              (cf),
    .empty_in        (empty_in),
    .almost_empty_in (almost_empty_in),
    .data_in         (data_in),
    .pop             (pop),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .chan_out        (chan_out),
    .paused          (paused),
    .pause_count     (pause_count)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a pop seen in a cycle without reset must yield exactly
  // one valid_out next cycle carrying that channel's data_in slice.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (valid_out !== exp_valid) begin
        errors++;
        $display("FAIL sb_valid: valid_out=%b expected=%b at %0t", valid_out, exp_valid, $time);
      end
      if (valid_out === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underrun: valid_out with no expected word at %0t", $time);
        end else begin
          mon_e = sb_q.pop_front();
          if (data_out !== mon_e.data || chan_out !== mon_e.chan) begin
            errors++;
            $display("FAIL sb_word: got chan=%0d data=%h expected chan=%0d data=%h at %0t",
                     chan_out, data_out, mon_e.chan, mon_e.data, $time);
          end
        end
      end
      checks++;
      if (!$onehot0(pop)) begin
        errors++;
        $display("FAIL pop_onehot: pop=%b at %0t", pop, $time);
      end
      exp_valid = 1'b0;
      if (pop !== '0 && rst === 1'b0) begin
        for (int i = 0; i < N; i++) begin
          if (pop[i] === 1'b1) begin
            mon_e.chan = 2'(i);
            mon_e.data = data_in[i*DW +: DW];
            sb_q.push_back(mon_e);
          end
        end
        exp_valid = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) data_in[i*DW +: DW] = base + DW'(i * 7 + 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; enb = 1'b1; cf = 4'b1111; empty_in = 4'b0000; almost_empty_in = 4'b0000;
    set_data(6'h10);
    step();
    step();
    mon_en = 1'b1;
    checks++; if (pop !== 4'b0000) begin errors++; $display("FAIL reset_pop: got %b expected 0000", pop); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (pause_count !== 8'd0) begin errors++; $display("FAIL reset_pcount: got %0d expected 0", pause_count); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL reset_paused: got %b expected 0", paused); end
    checks++; if (data_out !== '0 || chan_out !== 2'd0) begin
      errors++; $display("FAIL reset_data: data=%h chan=%0d expected 0/0", data_out, chan_out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ep;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      ep = 4'b0001 << (i % 4);
      checks++; if (pop !== ep) begin errors++; $display("FAIL rr_pop[%0d]: got %b expected %b", i, pop, ep); end
      if (i > 0) begin
        checks++;
        if (valid_out !== 1'b1 || chan_out !== 2'((i - 1) % 4)) begin
          errors++; $display("FAIL rr_out[%0d]: valid=%b chan=%0d expected 1/%0d", i, valid_out, chan_out, (i - 1) % 4);
        end
      end
    end
  endtask

  task automatic test_pause();
    cf = 4'b0000;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++; if (pop !== 4'b0000 || paused !== 1'b1 || pause_count !== 8'(i)) begin
        errors++; $display("FAIL pause[%0d]: pop=%b paused=%b count=%0d expected 0000/1/%0d", i, pop, paused, pause_count, i);
      end
    end
    cf = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pop !== 4'b0100 || paused !== 1'b0 || pause_count !== 8'd10) begin
        errors++; $display("FAIL unpause[%0d]: pop=%b paused=%b count=%0d expected 0100/0/10", i, pop, paused, pause_count);
      end
    end
    // Drain: all sources empty, in-flight word delivered.
    empty_in = 4'b1111;
    step();
    step();
  endtask

  task automatic test_underflow_guard();
    int nvalid = 0;
    logic [3:0] ep [4] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000};
    cf = 4'b1111; empty_in = 4'b1101; almost_empty_in = 4'b0010;
    set_data(6'h22);
    for (int i = 0; i < 4; i++) begin
      step();
      if (valid_out === 1'b1) nvalid++;
      checks++; if (pop !== ep[i]) begin errors++; $display("FAIL guard_pop[%0d]: got %b expected %b", i, pop, ep[i]); end
      if (i == 1) begin
        empty_in = 4'b1111;
        almost_empty_in = 4'b0000;
      end
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL guard_strobes: got %0d expected 1", nvalid); end
    checks++; if (paused !== 1'b0) begin errors++; $display("FAIL guard_paused: got %b expected 0", paused); end
  endtask

  task automatic test_enb_gating();
    logic [3:0] ep [6] = '{4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    empty_in = 4'b0000; cf = 4'b1111;
    set_data(6'h05);
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (pop !== ep[i] || valid_out !== ev[i]) begin
        errors++; $display("FAIL enb[%0d]: pop=%b valid=%b expected %b/%b", i, pop, valid_out, ep[i], ev[i]);
      end
      if (i == 1) enb = 1'b0;
      if (i == 4) enb = 1'b1;
    end
    checks++; if (pause_count !== 8'd10) begin errors++; $display("FAIL enb_pcount: got %0d expected 10", pause_count); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    checks++; if (pop !== 4'b0000 || valid_out !== 1'b0 || pause_count !== 8'd0 || data_out !== '0) begin
      errors++; $display("FAIL midrst: pop=%b valid=%b count=%0d data=%h expected 0000/0/0/00", pop, valid_out, pause_count, data_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    cf = 4'b0000; empty_in = 4'b0000;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254 || i == 255 || i == 300) begin
        checks++;
        if (pause_count !== ((i > 255) ? 8'd255 : 8'(i)) || paused !== 1'b1) begin
          errors++; $display("FAIL sat[%0d]: count=%0d paused=%b expected %0d/1", i, pause_count, paused, (i > 255) ? 255 : i);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_pause();
    test_underflow_guard();
    test_enb_gating();
    test_reset_mid();
    test_saturation();
    step();
    step();
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d words never delivered", sb_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
